imem_arbiter: RTL and testbench

Arbiter and sequencer for the word-addressed instruction memory (32-bit words, byte address with word index in bits [IDX_W+1:2]). It shares the single memory port between the pipeline fetch stage (read-only) and the debug/program-load port (read/write), enforces halt-before-write, and reports misaligned or out-of-range accesses. It sits between the IF stage and the memory array; the array's read remains combinational.

---
 rtl/imem_arbiter.sv | 134 +++++++++++++
 tb/tb_imem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Shares one instruction-memory port between fetch (read) and debug (read/write); RUN/DRAIN/HALTED sequencing.
// Grants are combinational, responses one cycle later; debug is forced through after STARVE_MAX denied cycles.
module imem_arbiter #(
    parameter int WORDS      = 256,
    parameter int STARVE_MAX = 4,
    parameter bit BOOT_HALT  = 1'b0,
    localparam int IDX_W     = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_req,
    input  logic [31:0]      fetch_addr,
    output logic             fetch_gnt,
    output logic             fetch_valid,
    output logic [31:0]      fetch_rdata,
    output logic             fetch_err,
    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [31:0]      dbg_addr,
    input  logic [31:0]      dbg_wdata,
    output logic             dbg_gnt,
    output logic             dbg_valid,
    output logic [31:0]      dbg_rdata,
    output logic             dbg_err,
    input  logic             dbg_halt,
    output logic             halted,
    output logic             cpu_stall,
    output logic [IDX_W-1:0] mem_addr,
    output logic             mem_we,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam state_t   RESET_STATE = BOOT_HALT ? ST_HALTED : ST_RUN;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state, state_nxt;
    logic [3:0] starve_cnt, starve_nxt;
    logic       fetch_bad, dbg_bad;
    logic       starved;

    // Misaligned, or any bit above the word index set.
    assign fetch_bad = (fetch_addr[1:0] != 2'b00) || (|fetch_addr[31:IDX_W+2]);
    assign dbg_bad   = (dbg_addr[1:0]   != 2'b00) || (|dbg_addr[31:IDX_W+2]);
    assign starved   = (starve_cnt == STARVE_LIM);

    always_comb begin
        state_nxt = state;
        fetch_gnt = 1'b0;
        dbg_gnt   = 1'b0;
        case (state)
            ST_RUN: begin
                dbg_gnt   = dbg_req && (!fetch_req || starved);
                fetch_gnt = fetch_req && !dbg_gnt;
                if (dbg_halt) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                dbg_gnt   = dbg_req;
                state_nxt = ST_HALTED;
            end
            ST_HALTED: begin
                dbg_gnt = dbg_req;
                if (!dbg_halt) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = RESET_STATE;
            end
        endcase
    end

    // The counter only advances on denials, which can only happen in RUN.
    always_comb begin
        starve_nxt = 4'd0;
        if (dbg_req && !dbg_gnt) begin
            starve_nxt = starved ? starve_cnt : starve_cnt + 4'd1;
        end
    end

    always_comb begin
        mem_addr = '0;
        if (fetch_gnt) begin
            mem_addr = fetch_addr[IDX_W+1:2];
        end else if (dbg_gnt) begin
            mem_addr = dbg_addr[IDX_W+1:2];
        end
    end

    // Gated by rst_n so that nothing is written during a reset cycle.
    assign mem_we    = rst_n && dbg_gnt && dbg_we && (state == ST_HALTED) && !dbg_bad;
    assign mem_wdata = dbg_wdata;

    assign halted    = (state == ST_HALTED);
    assign cpu_stall = (state != ST_RUN) || (fetch_req && !fetch_gnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RESET_STATE;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            fetch_rdata <= 32'd0;
            fetch_err   <= 1'b0;
            dbg_valid   <= 1'b0;
            dbg_rdata   <= 32'd0;
            dbg_err     <= 1'b0;
        end else begin
            fetch_valid <= fetch_gnt;
            fetch_err   <= fetch_gnt && fetch_bad;
            fetch_rdata <= (fetch_gnt && !fetch_bad) ? mem_rdata : 32'd0;
            dbg_valid   <= dbg_gnt;
            dbg_err     <= dbg_gnt && (dbg_bad || (dbg_we && (state != ST_HALTED)));
            // Writes and rejected accesses return zero data.
            dbg_rdata   <= (dbg_gnt && !dbg_we && !dbg_bad) ? mem_rdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed vectors, a transaction-level model compared every cycle,
// and a second instance built with BOOT_HALT=1.
module tb_imem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req, dbg_req, dbg_we, dbg_halt;
    logic [31:0] fetch_addr, dbg_addr, dbg_wdata;
    logic        fetch_gnt, fetch_valid, fetch_err, dbg_gnt, dbg_valid, dbg_err;
    logic        halted, cpu_stall, mem_we;
    logic [31:0] fetch_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;
    logic [31:0] mem [256];

    logic        b_fetch_req, b_dbg_halt;
    logic        b_fetch_gnt, b_fetch_valid, b_fetch_err, b_dbg_gnt, b_dbg_valid, b_dbg_err;
    logic        b_halted, b_cpu_stall, b_mem_we;
    logic [31:0] b_fetch_rdata, b_dbg_rdata, b_mem_wdata;
    logic [31:0] b_mem_rdata = 32'd0;
    logic [7:0]  b_mem_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.WORDS(256), .STARVE_MAX(STARVE_MAX), .BOOT_HALT(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_valid(dbg_valid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .dbg_halt(dbg_halt), .halted(halted), .cpu_stall(cpu_stall),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    imem_arbiter #(.WORDS(256), .STARVE_MAX(STARVE_MAX), .BOOT_HALT(1'b1)) u_boot (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(b_fetch_req), .fetch_addr(32'h0000_0004), .fetch_gnt(b_fetch_gnt),
        .fetch_valid(b_fetch_valid), .fetch_rdata(b_fetch_rdata), .fetch_err(b_fetch_err),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(32'd0), .dbg_wdata(32'd0),
        .dbg_gnt(b_dbg_gnt), .dbg_valid(b_dbg_valid), .dbg_rdata(b_dbg_rdata), .dbg_err(b_dbg_err),
        .dbg_halt(b_dbg_halt), .halted(b_halted), .cpu_stall(b_cpu_stall),
        .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Memory array: combinational read, write on the closing edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 10) != 0);
    endfunction

    // Reference model: mode 0=RUN 1=DRAIN 2=HALTED, advanced once per cycle.
    logic [31:0] ref_mem [256];
    int          m_state = 0;
    int          m_starve = 0;
    bit          model_on = 0;
    logic        x_fv = 0, x_fe = 0, x_dv = 0, x_de = 0;
    logic [31:0] x_frd = 0, x_drd = 0;

    always @(negedge clk) begin
        logic       efg, edg, ewe, fbad, dbad;
        logic [7:0] ea;
        fbad = addr_bad(fetch_addr);
        dbad = addr_bad(dbg_addr);
        efg = 0;
        edg = 0;
        if (m_state == 0) begin
            if (dbg_req && (!fetch_req || m_starve == STARVE_MAX)) edg = 1;
            else efg = fetch_req;
        end else begin
            edg = dbg_req;
        end
        ea  = efg ? fetch_addr[9:2] : (edg ? dbg_addr[9:2] : 8'd0);
        ewe = rst_n && edg && dbg_we && (m_state == 2) && !dbad;

        if (model_on) begin
            chk("m_fetch_gnt", 32'(fetch_gnt), 32'(efg));
            chk("m_dbg_gnt", 32'(dbg_gnt), 32'(edg));
            chk("m_mem_addr", 32'(mem_addr), 32'(ea));
            chk("m_mem_we", 32'(mem_we), 32'(ewe));
            if (ewe) chk("m_mem_wdata", mem_wdata, dbg_wdata);
            chk("m_halted", 32'(halted), 32'(m_state == 2));
            chk("m_cpu_stall", 32'(cpu_stall), 32'((m_state != 0) || (fetch_req && !efg)));
            chk("m_fetch_valid", 32'(fetch_valid), 32'(x_fv));
            chk("m_fetch_rdata", fetch_rdata, x_frd);
            chk("m_fetch_err", 32'(fetch_err), 32'(x_fe));
            chk("m_dbg_valid", 32'(dbg_valid), 32'(x_dv));
            chk("m_dbg_rdata", dbg_rdata, x_drd);
            chk("m_dbg_err", 32'(dbg_err), 32'(x_de));
        end

        if (!rst_n) begin
            if (!model_on) begin
                for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
                ref_mem[3] = 32'hDEAD_BEEF;
                ref_mem[4] = 32'hA5A5_0004;
            end
            model_on = 1;
            m_state  = 0;
            m_starve = 0;
            x_fv = 0; x_fe = 0; x_frd = 0;
            x_dv = 0; x_de = 0; x_drd = 0;
        end else begin
            x_fv  = efg;
            x_fe  = efg && fbad;
            x_frd = (efg && !fbad) ? ref_mem[fetch_addr[9:2]] : 32'd0;
            x_dv  = edg;
            x_de  = edg && (dbad || (dbg_we && m_state != 2));
            x_drd = (edg && !dbg_we && !dbad) ? ref_mem[dbg_addr[9:2]] : 32'd0;
            if (ewe) ref_mem[dbg_addr[9:2]] = dbg_wdata;
            if (m_state == 0 && dbg_req && !edg)
                m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
            else
                m_starve = 0;
            case (m_state)
                0:       m_state = dbg_halt ? 1 : 0;
                1:       m_state = 2;
                default: m_state = dbg_halt ? 2 : 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the 1-based cycle on which dbg_gnt rose, 0 if it never did.
    task automatic count_starve(output int gn);
        gn = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (dbg_gnt) begin
                gn = n;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gn;
        rst_n = 0; fetch_req = 0; fetch_addr = 0; dbg_req = 0; dbg_we = 0;
        dbg_addr = 0; dbg_wdata = 0; dbg_halt = 0;
        b_fetch_req = 1; b_dbg_halt = 1;
        for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
        mem[3] <= 32'hDEAD_BEEF;
        mem[4] <= 32'hA5A5_0004;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Reset state of both instances
        @(negedge clk);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_dbg_valid", 32'(dbg_valid), 32'd0);
        chk("rst_fetch_rdata", fetch_rdata, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("boot_halted", 32'(b_halted), 32'd1);
        chk("boot_cpu_stall", 32'(b_cpu_stall), 32'd1);
        chk("boot_no_fetch", 32'(b_fetch_gnt), 32'd0);

        // Plain fetch of word 3
        tick(); fetch_req = 1; fetch_addr = 32'h0C;
        @(negedge clk);
        chk("f0c_gnt", 32'(fetch_gnt), 32'd1);
        chk("f0c_addr", 32'(mem_addr), 32'd3);
        tick(); fetch_req = 0;
        @(negedge clk);
        chk("f0c_valid", 32'(fetch_valid), 32'd1);
        chk("f0c_rdata", fetch_rdata, 32'hDEAD_BEEF);
        chk("f0c_err", 32'(fetch_err), 32'd0);

        // Starvation: debug forced through on the fifth request cycle
        tick(); fetch_req = 1; fetch_addr = 32'h0; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h10;
        count_starve(gn);
        chk("starve_cycle", 32'(gn), 32'd5);
        chk("starve_no_fetch", 32'(fetch_gnt), 32'd0);
        chk("starve_stall", 32'(cpu_stall), 32'd1);
        tick(); fetch_req = 0; dbg_req = 0;
        @(negedge clk);
        chk("starve_dvalid", 32'(dbg_valid), 32'd1);
        chk("starve_drdata", dbg_rdata, 32'hA5A5_0004);

        // Write in RUN is refused
        tick(); dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("wrun_gnt", 32'(dbg_gnt), 32'd1);
        chk("wrun_we", 32'(mem_we), 32'd0);
        tick(); dbg_req = 0; dbg_halt = 1;
        @(negedge clk);
        chk("wrun_err", 32'(dbg_err), 32'd1);
        chk("wrun_mem", mem[8], 32'd0);
        chk("halt_req_run", 32'(halted), 32'd0);
        tick();
        @(negedge clk);
        chk("drain_halted", 32'(halted), 32'd0);
        chk("drain_stall", 32'(cpu_stall), 32'd1);
        tick(); dbg_req = 1;
        @(negedge clk);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_we", 32'(mem_we), 32'd1);
        chk("halt_wdata", mem_wdata, 32'h1234_5678);
        tick(); dbg_req = 0; dbg_halt = 0;
        @(negedge clk);
        chk("whalt_valid", 32'(dbg_valid), 32'd1);
        chk("whalt_err", 32'(dbg_err), 32'd0);
        tick(); fetch_req = 1; fetch_addr = 32'h20;
        @(negedge clk);
        chk("f20_gnt", 32'(fetch_gnt), 32'd1);
        tick(); fetch_req = 0;
        @(negedge clk);
        chk("f20_rdata", fetch_rdata, 32'h1234_5678);

        // Bad addresses are granted and flagged
        tick(); fetch_req = 1; fetch_addr = 32'h402;
        @(negedge clk);
        chk("f402_gnt", 32'(fetch_gnt), 32'd1);
        tick(); fetch_addr = 32'h400;
        @(negedge clk);
        chk("f402_err", 32'(fetch_err), 32'd1);
        chk("f402_rdata", fetch_rdata, 32'd0);
        chk("f400_gnt", 32'(fetch_gnt), 32'd1);
        tick(); fetch_req = 0;
        @(negedge clk);
        chk("f400_valid", 32'(fetch_valid), 32'd1);
        chk("f400_err", 32'(fetch_err), 32'd1);
        chk("f400_we", 32'(mem_we), 32'd0);

        // Reset right after a grant, with starvation partly built up
        tick(); fetch_req = 1; fetch_addr = 32'h0C; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h10;
        tick(); tick();
        tick(); rst_n = 0;
        tick(); rst_n = 1;
        @(negedge clk);
        chk("mrst_fvalid", 32'(fetch_valid), 32'd0);
        chk("mrst_dvalid", 32'(dbg_valid), 32'd0);
        chk("mrst_dgnt", 32'(dbg_gnt), 32'd0);
        tick();
        count_starve(gn);
        chk("mrst_starve", 32'(gn), 32'd4);
        tick(); fetch_req = 0; dbg_req = 0;

        // BOOT_HALT instance leaves HALTED one cycle after halt is released
        @(negedge clk);
        chk("boot_hold_gnt", 32'(b_fetch_gnt), 32'd0);
        tick(); b_dbg_halt = 0;
        @(negedge clk);
        chk("boot_rel_gnt", 32'(b_fetch_gnt), 32'd0);
        chk("boot_rel_halted", 32'(b_halted), 32'd1);
        tick();
        @(negedge clk);
        chk("boot_run_halted", 32'(b_halted), 32'd0);
        chk("boot_run_gnt", 32'(b_fetch_gnt), 32'd1);
        chk("boot_run_stall", 32'(b_cpu_stall), 32'd0);
        tick();
        @(negedge clk);
        chk("boot_run_valid", 32'(b_fetch_valid), 32'd1);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
